jtvigil_scrn: RTL
=================

# jtvigil_scrn

Parametrised scroll-layer line renderer for the Vigilante video pipeline, successor to the fixed background scroll block. On each line start it fetches one row of packed 4bpp graphics from ROM through a cs/ok handshake, unpacks it into a double-buffered line buffer, and streams pixels out with fine horizontal scroll. The output pixel bus feeds the colour mixer, and the ROM port feeds the SDRAM arbiter. Screen width, scroll range, row count and palette width are set by parameters, so one module serves every scroll plane.

## Interface
Parameters:
- SCRW, 256: visible pixels per line; multiple of 8.
- HSCRW, 9: horizontal scroll width; layer width is 2^HSCRW pixels.
- VW, 8: row index width.
- PALW, 4: palette bits per line.
- AW, VW+HSCRW-3: ROM word address width.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset; sampled on clk rising edge.
- pxl_cen  in  1  pixel clock enable.
- hs  in  1  horizontal sync; rising edge marks line start.
- vrender  in  VW  row to fetch for the next line.
- hdump  in  9  current output pixel column.
- scrx  in  HSCRW  horizontal scroll, sampled at line start.
- pal  in  PALW  palette for the fetched line, sampled at line start.
- rom_addr  out  AW  {row, column group}.
- rom_cs  out  1  ROM request.
- rom_ok  in  1  data valid for the current rom_addr.
- rom_data  in  32  8 pixels at 4bpp, pixel 0 in bits [3:0].
- pxl  out  PALW+4  {palette, colour}; colour 0 is transparent.
- ovr  out  1  sticky flag: a line start arrived before the fetch finished.

## Operation
- The line buffer has two banks of SCRW+8 entries, each PALW+4 bits wide. One bank is written by the fetch while the other is read by the output.
- Line start is the rising edge of hs, detected on clk. On line start:
  - swap banks;
  - latch scrx, pal and vrender;
  - set group counter g=0;
  - move to REQ.
- Fetch FSM states:
  - IDLE.
  - REQ: drive rom_addr = {vrender_l, scrx_l[HSCRW-1:3]+g}, with the column add wrapping modulo 2^(HSCRW-3). Assert rom_cs and go to WAIT.
  - WAIT: hold rom_cs and rom_addr stable until rom_ok=1. Capture rom_data, drop rom_cs, go to WRITE.
  - WRITE: write one pixel per clk, {pal_l, nibble k}, to entry 8g+k for k=0..7. After k=7: g++; return to REQ if g<SCRW/8+1, else IDLE.
- Output path, one action per pxl_cen:
  - if hdump<SCRW, read entry hdump+scrx_l[2:0] from the read bank;
  - otherwise output 0.
- Line start during REQ, WAIT or WRITE:
  - abort the fetch, set ovr=1, and start the new line;
  - entries not written in the aborted line keep stale data;
  - ovr is cleared only by reset.
- rom_ok while rom_cs=0 is ignored.

## Timing
- Reset values:
  - rom_cs=0, rom_addr=0, pxl=0, ovr=0;
  - FSM in IDLE, write bank 0, g=0;
  - latched scrx, pal and vrender all 0.
- Line start is recognised 1 clk after hs rises. rom_cs asserts on the following clk.
- Each group costs 1 (REQ) + N (WAIT, N≥1) + 8 (WRITE) clks. With rom_ok returned on the first WAIT cycle, a full fetch of SCRW/8+1 groups takes 10·(SCRW/8+1) clks.
- rom_addr is constant for as long as rom_cs=1.
- pxl is registered and updates 1 clk after a pxl_cen cycle.
- A line fetched during line n is displayed during line n+1.
- Reset asserted mid-fetch: rom_cs drops on the next clk and no buffer write happens on that clk.

## Configuration
- JTVIGIL_SCRN_FLIP_EN defined:
  - adds input port flip (1 bit), sampled at line start;
  - when flip=1, the output reads entry (SCRW-1-hdump)+scrx_l[2:0];
  - ROM addressing is unchanged.
- Not defined:
  - no flip port;
  - the output always uses direct order.

## Test plan
- Reset: hold rst=0 for 4 clks while hs toggles → rom_cs=0, pxl=0, ovr=0 throughout.
- Basic fetch: SCRW=256, scrx=0, vrender=5, rom_ok returned 1 clk after rom_cs → 33 requests at addresses {5,0}..{5,32}, then IDLE. Next line: pxl colour at hdump=0..7 equals nibbles 0..7 of the first word.
- Fine scroll: scrx=3 → next line pxl at hdump=0 equals nibble 3 of group 0; at hdump=5, nibble 0 of group 1.
- Wrap: HSCRW=9, scrx=500 → group column runs 62, 63, 0, 1, …, 30.
- Slow ROM / overrun: rom_ok delayed 20 clks, hs period 400 clks → the fetch aborts and ovr=1 stays set. rom_addr never changes while rom_cs=1.
- Flip (macro on): flip=1, scrx=0 → pxl at hdump=0 equals entry 255, and at hdump=255 equals entry 0.

Source files
------------

// File: rtl/jtvigil_scrn.sv
// Scroll-layer line renderer: fetches one 4bpp row per line into a double-buffered line buffer; JTVIGIL_SCRN_FLIP_EN adds a flip input.
// pxl is registered one clk after pxl_cen; the ROM is held until rom_ok, and a new line start aborts the fetch and sets ovr.
module jtvigil_scrn #(
  parameter int SCRW  = 256,
  parameter int HSCRW = 9,
  parameter int VW    = 8,
  parameter int PALW  = 4,
  parameter int AW    = VW+HSCRW-3
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             pxl_cen,
  input  logic             hs,
`ifdef JTVIGIL_SCRN_FLIP_EN
  input  logic             flip,
`endif
  input  logic [VW-1:0]    vrender,
  input  logic [8:0]       hdump,
  input  logic [HSCRW-1:0] scrx,
  input  logic [PALW-1:0]  pal,
  output logic [AW-1:0]    rom_addr,
  output logic             rom_cs,
  input  logic             rom_ok,
  input  logic [31:0]      rom_data,
  output logic [PALW+3:0]  pxl,
  output logic             ovr
);

  localparam int NGRP  = SCRW/8+1;
  localparam int DEPTH = SCRW+8;
  localparam int IW    = $clog2(DEPTH);
  localparam int GW    = $clog2(NGRP+1);
  localparam int CW    = HSCRW-3;
  localparam int PW    = PALW+4;
  localparam logic [9:0]    SCRW_V = 10'(SCRW);
  localparam logic [GW-1:0] GLAST  = GW'(NGRP-1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_WRITE} state_t;

  state_t           state, nxt;
  logic             hs_l;
  logic             line_start;
  logic [HSCRW-1:0] scrx_l;
  logic [PALW-1:0]  pal_l;
  logic [VW-1:0]    vrender_l;
  logic [GW-1:0]    g;
  logic [2:0]       k;
  logic [31:0]      dat_l;
  logic             wbank;
  logic             we;
  logic [CW-1:0]    col;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_col;
  logic [IW-1:0]    rd_idx;
  logic [PW-1:0]    lbuf [2][DEPTH];
`ifdef JTVIGIL_SCRN_FLIP_EN
  logic             flip_l;
`endif

  assign line_start = hs & ~hs_l;
  // Column group wraps around the scroll layer width
  assign col    = scrx_l[HSCRW-1:3] + CW'(g);
  assign wr_idx = IW'({g, k});

`ifdef JTVIGIL_SCRN_FLIP_EN
  assign rd_col = flip_l ? (IW'(SCRW-1) - IW'(hdump)) : IW'(hdump);
`else
  assign rd_col = IW'(hdump);
`endif
  assign rd_idx = rd_col + IW'(scrx_l[2:0]);

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    we  = 1'b0;
    case (state)
      ST_REQ:   nxt = ST_WAIT;
      ST_WAIT:  if (rom_ok && rom_cs) nxt = ST_WRITE;
      ST_WRITE: begin
        we = 1'b1;
        if (k == 3'd7) nxt = (g == GLAST) ? ST_IDLE : ST_REQ;
      end
      default:  nxt = state;
    endcase
    // A new line always wins; the aborted group is not written
    if (line_start) begin
      nxt = ST_REQ;
      we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hs_l      <= hs;
      scrx_l    <= '0;
      pal_l     <= '0;
      vrender_l <= '0;
      g         <= '0;
      k         <= '0;
      dat_l     <= '0;
      wbank     <= 1'b0;
      rom_cs    <= 1'b0;
      rom_addr  <= '0;
      ovr       <= 1'b0;
`ifdef JTVIGIL_SCRN_FLIP_EN
      flip_l    <= 1'b0;
`endif
    end else begin
      hs_l <= hs;
      if (line_start) begin
        wbank     <= ~wbank;
        scrx_l    <= scrx;
        pal_l     <= pal;
        vrender_l <= vrender;
        g         <= '0;
        k         <= '0;
        rom_cs    <= 1'b0;
        if (state != ST_IDLE) ovr <= 1'b1;
`ifdef JTVIGIL_SCRN_FLIP_EN
        flip_l    <= flip;
`endif
      end else begin
        case (state)
          ST_REQ: begin
            rom_cs   <= 1'b1;
            rom_addr <= AW'({vrender_l, col});
          end
          ST_WAIT: begin
            if (rom_ok && rom_cs) begin
              rom_cs <= 1'b0;
              dat_l  <= rom_data;
            end
          end
          ST_WRITE: begin
            k <= k + 3'd1;
            if (k == 3'd7) g <= g + GW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // Buffer contents are not cleared by reset; reset only blocks the write
  always_ff @(posedge clk) begin
    if (rst && we) lbuf[wbank][wr_idx] <= {pal_l, dat_l[{k, 2'b00} +: 4]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pxl <= '0;
    end else if (pxl_cen) begin
      pxl <= ({1'b0, hdump} < SCRW_V) ? lbuf[~wbank][rd_idx] : '0;
    end
  end

endmodule
